// File: rtl/mod_count_pkg.sv
// mod_count_pkg: definitions shared by the mod-N count checker and by the
// mod-N counter that it watches.
//   state_t    checker FSM encoding (HUNT/TRACK/LOCKED/ERROR)
//   DEF_*      default modulus and count width (mod-9, 4 bits)
//   next_exp   next value of a 0..modulus-1 wrapping sequence
package mod_count_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam int unsigned DEF_MODULUS = 9;
    localparam int unsigned DEF_WIDTH   = 4;

    function automatic int unsigned next_exp(input int unsigned prev,
                                             input int unsigned modulus);
        return (prev == modulus - 1) ? 0 : prev + 1;
    endfunction

endpackage

// File: rtl/mod_count_checker_if.sv
// mod_count_checker_if: sample stream into the checker and its status back out.
//   valid      sample qualifier
//   Dat        count value under check (WIDTH bits)
//   locked     checker is in LOCKED
//   wrap/err   one-cycle event pulses
//   wrapCount  accepted wraps (CNT_W bits, rolls over)
//   errCount   violations (CNT_W bits, saturating)
// master: the stream source / monitor side. slave: the checker.
interface mod_count_checker_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             valid;
    logic [WIDTH-1:0] Dat;
    logic             locked;
    logic             wrap;
    logic             err;
    logic [CNT_W-1:0] wrapCount;
    logic [CNT_W-1:0] errCount;

    modport master (output valid, Dat,
                    input  locked, wrap, err, wrapCount, errCount);
    modport slave  (input  valid, Dat,
                    output locked, wrap, err, wrapCount, errCount);
endinterface

// File: rtl/mod_count_checker_sat_counter.sv
// sat_counter: CNT_W-bit event counter.
//   clk, rst_n  clock, async active-low reset
//   inc         count one event this cycle
//   sat_en      1: hold at all-ones, 0: roll over to zero
//   cnt         current count
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             sat_en,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && !(sat_en && (&cnt)))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mod_count_checker.sv
// mod_count_checker: locks onto a 0..MODULUS-1 wrapping count stream and
// reports accepted wraps and sequence violations.
//   clkIn, rstN  clock, async active-low reset
//   bus (slave)  valid/Dat in; locked, wrap, err, wrapCount, errCount out
// Build option MOD_COUNT_CHECK_STICKY_EN: a violation while locked parks the
// FSM in ERROR until reset; otherwise the checker drops to HUNT and relocks.
module mod_count_checker
    import mod_count_pkg::*;
#(
    parameter int unsigned MODULUS    = DEF_MODULUS,
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               clkIn,
    input  logic               rstN,
    mod_count_checker_if.slave bus
);
    localparam int unsigned      MW    = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [MW-1:0]    match_cnt;

    logic [WIDTH-1:0] exp_val;
    logic             legal;
    logic             match;
    logic             take_wrap;
    logic             take_err;

    // Event decode is combinational so the counters step on the same edge
    // that registers the wrap/err pulses.
    always_comb begin
        exp_val   = WIDTH'(next_exp(32'(prev), MODULUS));
        legal     = {1'b0, bus.Dat} < MOD_V;
        match     = legal && (bus.Dat == exp_val);
        take_wrap = bus.valid && (state == LOCKED) && match && (prev == LAST);
        take_err  = bus.valid && (state == LOCKED) && !match;
    end

    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            state      <= HUNT;
            prev       <= '0;
            match_cnt  <= '0;
            bus.locked <= 1'b0;
            bus.wrap   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.wrap <= take_wrap;
            bus.err  <= take_err;
            if (bus.valid) begin
                case (state)
                    HUNT: begin
                        if (legal) begin
                            prev      <= bus.Dat;
                            match_cnt <= '0;
                            state     <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (match) begin
                            prev <= bus.Dat;
                            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                                match_cnt  <= '0;
                                state      <= LOCKED;
                                bus.locked <= 1'b1;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else if (legal) begin
                            // Restart the run from the new value.
                            prev      <= bus.Dat;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= '0;
                            state     <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            prev <= bus.Dat;
                        end else begin
                            bus.locked <= 1'b0;
`ifdef MOD_COUNT_CHECK_STICKY_EN
                            state <= ERROR;
`else
                            state <= HUNT;
`endif
                        end
                    end
                    default: ;  // ERROR: frozen until reset
                endcase
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
        .clk    (clkIn),
        .rst_n  (rstN),
        .inc    (take_wrap),
        .sat_en (1'b0),
        .cnt    (bus.wrapCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk    (clkIn),
        .rst_n  (rstN),
        .inc    (take_err),
        .sat_en (1'b1),
        .cnt    (bus.errCount)
    );
endmodule

// File: tb/tb_mod_count_checker.sv
// tb_mod_count_checker: directed check of mod_count_checker (mod-9, 4-bit,
// LOCK_COUNT=2, 8-bit counters). Expectations follow the sticky build when
// MOD_COUNT_CHECK_STICKY_EN is defined.
module tb_mod_count_checker;
    logic clkIn = 1'b0;
    logic rstN  = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   nxt;

    always #5 clkIn = ~clkIn;

    mod_count_checker_if #(.WIDTH(4), .CNT_W(8)) bus();

    mod_count_checker #(
        .MODULUS(9), .WIDTH(4), .LOCK_COUNT(2), .CNT_W(8)
    ) dut (
        .clkIn (clkIn),
        .rstN  (rstN),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic feed(input int v);
        bus.valid = 1'b1;
        bus.Dat   = 4'(v);
        @(posedge clkIn);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid = 1'b0;
        repeat (n) begin
            @(posedge clkIn);
            #1;
        end
    endtask

    task automatic run(input int start, input int n, output int next);
        int v;
        v = start;
        repeat (n) begin
            feed(v);
            v = (v == 8) ? 0 : v + 1;
        end
        next = v;
    endtask

    task automatic do_reset();
        rstN      = 1'b0;
        bus.valid = 1'b0;
        repeat (2) @(posedge clkIn);
        #1;
        rstN = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, 32'(bus.locked), 0);
        chk({tag, "_wrap"},   32'(bus.wrap), 0);
        chk({tag, "_err"},    32'(bus.err), 0);
        chk({tag, "_wcnt"},   32'(bus.wrapCount), 0);
        chk({tag, "_ecnt"},   32'(bus.errCount), 0);
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.Dat   = '0;
        repeat (2) @(posedge clkIn);
        #1;
        chk_all_zero("reset");
        rstN = 1'b1;

        // Acquire: locked after the third sample.
        feed(0); chk("lock_s1", 32'(bus.locked), 0);
        feed(1); chk("lock_s2", 32'(bus.locked), 0);
        feed(2); chk("lock_s3", 32'(bus.locked), 1);
        run(3, 6, nxt);
        chk("no_wrap_at_8", 32'(bus.wrap), 0);
        feed(0);
        chk("wrap1", 32'(bus.wrap), 1);
        chk("wcnt1", 32'(bus.wrapCount), 1);
        feed(1);
        chk("wrap_pulse_end", 32'(bus.wrap), 0);
        run(2, 16, nxt);
        feed(0);
        chk("wcnt3", 32'(bus.wrapCount), 3);

        // Inject 5 where 3 is expected.
        feed(1); feed(2); feed(5);
        chk("inj_err", 32'(bus.err), 1);
        chk("inj_ecnt", 32'(bus.errCount), 1);
        chk("inj_unlock", 32'(bus.locked), 0);
        feed(6);
        chk("err_pulse_end", 32'(bus.err), 0);
        feed(7);
        chk("relock_mid", 32'(bus.locked), 0);
        feed(8);
`ifdef MOD_COUNT_CHECK_STICKY_EN
        chk("sticky_locked", 32'(bus.locked), 0);
        feed(0);
        chk("sticky_wrap", 32'(bus.wrap), 0);
        chk("sticky_wcnt", 32'(bus.wrapCount), 3);
        chk("sticky_err", 32'(bus.err), 0);
        feed(5);
        chk("sticky_err2", 32'(bus.err), 0);
        chk("sticky_ecnt", 32'(bus.errCount), 1);
`else
        chk("relock", 32'(bus.locked), 1);
        feed(0);
        chk("relock_wrap", 32'(bus.wrap), 1);
        chk("relock_wcnt", 32'(bus.wrapCount), 4);
        chk("relock_ecnt", 32'(bus.errCount), 1);
`endif

        // Async reset mid-stream, checked before any clock edge.
        rstN = 1'b0;
        #2;
        chk_all_zero("async_rst");
        @(posedge clkIn);
        #1;
        rstN = 1'b1;

        // valid low for 10 cycles while locked.
        run(0, 4, nxt);
        chk("gap_pre_locked", 32'(bus.locked), 1);
        idle(10);
        chk("gap_locked", 32'(bus.locked), 1);
        chk("gap_err", 32'(bus.err), 0);
        feed(4);
        chk("gap_resume_err", 32'(bus.err), 0);
        chk("gap_resume_locked", 32'(bus.locked), 1);
        run(5, 4, nxt);
        feed(0);
        chk("gap_wrap", 32'(bus.wrap), 1);
        chk("gap_wcnt", 32'(bus.wrapCount), 1);

        // Illegal values during HUNT and TRACK.
        do_reset();
        feed(11);
        chk("ill_hunt_err", 32'(bus.err), 0);
        chk("ill_hunt_locked", 32'(bus.locked), 0);
        feed(3); feed(4); feed(11);
        chk("ill_track_err", 32'(bus.err), 0);
        feed(5); chk("ill_reacq1", 32'(bus.locked), 0);
        feed(6); chk("ill_reacq2", 32'(bus.locked), 0);
        feed(7); chk("ill_reacq3", 32'(bus.locked), 1);
        chk("ill_ecnt", 32'(bus.errCount), 0);
        chk("ill_wcnt", 32'(bus.wrapCount), 0);

`ifndef MOD_COUNT_CHECK_STICKY_EN
        // errCount saturation: lock, then violate, 260 times.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            run(0, 3, nxt);
            feed(7);
            if (i == 253) chk("ecnt_254", 32'(bus.errCount), 254);
        end
        chk("ecnt_sat", 32'(bus.errCount), 255);
        chk("err_at_sat", 32'(bus.err), 1);
`endif

        // wrapCount rollover after 256 wraps.
        do_reset();
        run(0, 9 * 255 + 1, nxt);
        chk("wcnt_255", 32'(bus.wrapCount), 255);
        run(nxt, 9, nxt);
        chk("wcnt_roll", 32'(bus.wrapCount), 0);
        chk("wrap_at_roll", 32'(bus.wrap), 1);
        chk("roll_ecnt", 32'(bus.errCount), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mod_count_checker.md
# mod_count_checker

Receive-side checker for a mod-N counter output stream. Samples a WIDTH-bit count value on each qualified clock, locks onto the 0..MODULUS-1 wrapping sequence, and reports each completed wrap plus any out-of-sequence value. It sits downstream of a mod-N counter such as the mod-9 counter, and bench-tops and in-system monitors use it to prove counter integrity.

## Interface
- MODULUS, 9: sequence length; legal values 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH
- WIDTH, 4: input count width
- LOCK_COUNT, 2: consecutive correct transitions required to enter LOCKED; ≥1
- CNT_W, 8: width of wrap and error counters
- clkIn  input  1  clock, all state on rising edge
- rstN  input  1  asynchronous active-low reset
- valid  input  1  Dat sampled this cycle when high
- Dat  input  WIDTH  count value under check
- locked  output  1  high while FSM in LOCKED
- wrap  output  1  one-cycle pulse: MODULUS-1 → 0 transition accepted in LOCKED
- err  output  1  one-cycle pulse: sequence violation detected in LOCKED
- wrapCount  output  CNT_W  accepted wraps, modulo 2^CNT_W
- errCount  output  CNT_W  violations, saturating at all-ones

## Operation
- Expected next value: exp = (prev == MODULUS-1) ? 0 : prev+1; prev is last sampled Dat.
- Any Dat ≥ MODULUS is illegal; always a mismatch.
- States: HUNT, TRACK, LOCKED, ERROR.
- HUNT: on valid with legal Dat → store prev, matchCnt=0, go TRACK. Illegal Dat → stay HUNT, prev unchanged.
- TRACK: on valid, Dat==exp → matchCnt+1, prev=Dat; when matchCnt reaches LOCK_COUNT → LOCKED. Mismatch → prev=Dat if legal, matchCnt=0, stay TRACK; if illegal → HUNT. No err pulse in HUNT/TRACK.
- LOCKED: on valid, Dat==exp → prev=Dat; if transition was MODULUS-1→0, pulse wrap, wrapCount+1. Mismatch → pulse err, errCount+1 (saturating), go ERROR (sticky build) or HUNT (default).
- valid low: no state, prev, or counter change in any state; outputs pulses low.
- Wrap and error on same sample impossible (mutually exclusive by definition).
- wrapCount wraps all-ones → 0 silently; errCount holds at all-ones.

## Timing
- Reset (async assert, sync release on clkIn): state=HUNT, prev=0, matchCnt=0, locked=0, wrap=0, err=0, wrapCount=0, errCount=0.
- All outputs registered; latency one clkIn from the sampling edge of valid/Dat to wrap/err/locked update.
- locked rises on the edge that accepts the LOCK_COUNT-th correct transition, i.e. after LOCK_COUNT+1 valid samples from HUNT.
- Reset asserted mid-operation: immediate return to reset values regardless of clock; pending pulses dropped.
- No back-pressure; valid may toggle every cycle.

## Configuration
- MOD_COUNT_CHECK_STICKY_EN defined: LOCKED mismatch → ERROR; ERROR ignores all input, locked=0, holds until rstN asserted; err pulses once only.
- Undefined: ERROR state unreachable; LOCKED mismatch → HUNT and re-acquisition proceeds automatically; errCount accumulates across relocks.

## Structure
- Shared package mod_count_pkg: state encoding constants (HUNT=2'd0, TRACK=2'd1, LOCKED=2'd2, ERROR=2'd3), default MODULUS/WIDTH, and a next-expected-value function shared with the counter.
- One sub-module: sat_counter (parameter CNT_W, inputs inc/saturate-enable) instantiated twice, for wrapCount (non-saturating) and errCount (saturating).

## Test plan
- Reset, then feed a mod-9 counter stream 0..8 repeated with valid=1 → locked=1 one cycle after the third sample; wrap pulses every 9 samples; wrapCount=3 after 3 wraps.
- Locked, inject Dat=5 where 3 expected → err pulse one cycle later, errCount=1, locked=0; default build relocks after 3 good samples.
- Same injection with MOD_COUNT_CHECK_STICKY_EN → locked stays 0, no further err/wrap despite good stream until rstN pulse.
- Dat=4'b1011 (≥9) during HUNT and TRACK → state returns/stays HUNT, no err, counters 0.
- valid held low for 10 cycles mid-stream while locked, then resume with the correct next value → no err, locked stays 1.
- Force errCount past 255 with CNT_W=8 → holds 255; 256 wraps → wrapCount=0; assert rstN mid-stream → all outputs 0 immediately.
